// File: rtl/seq_dp_pkg.sv
// seq_dp_pkg: opcodes, sequencer states and legality check shared by the datapath
package seq_dp_pkg;
  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_NOT  = 4'd4;
  localparam logic [3:0] OP_NEG  = 4'd5;
  localparam logic [3:0] OP_SHL  = 4'd6;
  localparam logic [3:0] OP_SHR  = 4'd7;
  localparam logic [3:0] OP_SHRA = 4'd8;
  localparam logic [3:0] OP_ROL  = 4'd9;
  localparam logic [3:0] OP_ROR  = 4'd10;
  localparam logic [3:0] OP_MUL  = 4'd11;

  typedef enum logic [2:0] {IDLE, T1, T2, T3, T4} state_t;

  function automatic logic is_legal(input logic [3:0] op);
    return op <= OP_MUL;
  endfunction
endpackage

// File: rtl/seq_dp_alu.sv
// seq_dp_alu: combinational ALU producing a double-width {hi, lo} result
module seq_dp_alu
  import seq_dp_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);
  localparam int SW = $clog2(WIDTH);
  logic [SW-1:0] sh;
  logic [2*WIDTH-1:0] prod;
  assign sh = b[SW-1:0];
  assign prod = $signed({{WIDTH{y[WIDTH-1]}}, y}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
  // Only MUL produces a high half; every other opcode leaves it zero
  always_comb begin
    hi = '0;
    case (op)
      OP_ADD:  lo = y + b;
      OP_SUB:  lo = y - b;
      OP_AND:  lo = y & b;
      OP_OR:   lo = y | b;
      OP_NOT:  lo = ~y;
      OP_NEG:  lo = -y;
      OP_SHL:  lo = y << sh;
      OP_SHR:  lo = y >> sh;
      OP_SHRA: lo = $signed(y) >>> sh;
      OP_ROL:  lo = (y << sh) | (y >> (WIDTH - int'(sh)));
      OP_ROR:  lo = (y >> sh) | (y << (WIDTH - int'(sh)));
      OP_MUL:  begin
        lo = prod[WIDTH-1:0];
        hi = prod[2*WIDTH-1:WIDTH];
      end
      default: lo = '0;
    endcase
  end
endmodule

// File: rtl/seq_bus_datapath.sv
// seq_bus_datapath: single-bus register datapath stepping one ALU command through T1..T4
module seq_bus_datapath
  import seq_dp_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int NREGS = 16,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [AW-1:0]    ra,
  input  logic [AW-1:0]    rb,
  input  logic [AW-1:0]    rc,
  output logic             busy,
  output logic             done,
  output logic             err,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  state_t state;
  logic [WIDTH-1:0] regs [NREGS];
  logic [WIDTH-1:0] y, zlo, zhi, bus, alu_lo, alu_hi;
  logic [3:0] op_q;
  logic [AW-1:0] ra_q, rb_q, rc_q;

  assign bus = state == T1 ? regs[rb_q] : regs[rc_q];
  assign rd_data = regs[rd_addr];

  seq_dp_alu #(.WIDTH(WIDTH)) u_alu (
    .op(op_q),
    .y (y),
    .b (bus),
    .lo(alu_lo),
    .hi(alu_hi)
  );

  // Sequencer: command latch, T-step transfers, register file and handshake flags
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      y <= '0;
      zlo <= '0;
      zhi <= '0;
      hi <= '0;
      lo <= '0;
      op_q <= '0;
      ra_q <= '0;
      rb_q <= '0;
      rc_q <= '0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      done <= 1'b0;
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_q <= op;
            ra_q <= ra;
            rb_q <= rb;
            rc_q <= rc;
            busy <= 1'b1;
            state <= T1;
          end else if (wr_en) regs[wr_addr] <= wr_data;
        end
        T1: begin
          y <= bus;
          state <= T2;
        end
        T2: begin
          zlo <= alu_lo;
          zhi <= alu_hi;
          state <= T3;
        end
        T3: begin
          if (op_q == OP_MUL) begin
            lo <= zlo;
            state <= T4;
          end else begin
            if (is_legal(op_q)) regs[ra_q] <= zlo;
            else err <= 1'b1;
            done <= 1'b1;
            busy <= 1'b0;
            state <= IDLE;
          end
        end
        T4: begin
          hi <= zhi;
          done <= 1'b1;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_bus_datapath.sv
// tb_seq_bus_datapath: directed commands with a queue of expected completions
module tb_seq_bus_datapath;
  import seq_dp_pkg::*;

  logic clk = 0, clr = 1, start = 0, wr_en = 0;
  logic [3:0] op = 0, ra = 0, rb = 0, rc = 0, wr_addr = 0, rd_addr = 0;
  logic [31:0] wr_data = 0;
  logic busy, done, err;
  logic [31:0] rd_data, hi, lo;
  int vectors = 0, miscompares = 0;

  typedef struct packed {
    logic [3:0]  lat;
    logic        err;
    logic        mul;
    logic [3:0]  dst;
    logic [31:0] val;
    logic [31:0] hv;
    logic [31:0] lv;
  } exp_t;
  exp_t q[$];

  seq_bus_datapath dut (
    .clk(clk), .clr(clr), .start(start), .op(op), .ra(ra), .rb(rb), .rc(rc),
    .busy(busy), .done(done), .err(err), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    wr_en = 1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_en = 0;
  endtask

  task automatic check_reg(input string tag, input logic [3:0] a, input logic [31:0] exp);
    rd_addr = a;
    #1;
    check(tag, rd_data, exp);
  endtask

  // Drives one command; with poke set, start and wr_en are also raised during T1/T2
  task automatic issue(input string tag, input logic [3:0] o, input logic [3:0] a,
                       input logic [3:0] b, input logic [3:0] c, input exp_t e, input bit poke);
    int n;
    exp_t got;
    q.push_back(e);
    op = o; ra = a; rb = b; rc = c; start = 1;
    tick();
    start = 0;
    check({tag, "_busy"}, busy, 1);
    n = 0;
    while (!done && n < 20) begin
      start = poke && n < 2;
      wr_en = poke && n < 2;
      tick();
      n++;
    end
    start = 0;
    wr_en = 0;
    got = q.pop_front();
    check({tag, "_lat"}, n, got.lat);
    check({tag, "_err"}, err, got.err);
    check({tag, "_busy_end"}, busy, 0);
    if (got.mul) begin
      check({tag, "_lo"}, lo, got.lv);
      check({tag, "_hi"}, hi, got.hv);
    end else check_reg({tag, "_dst"}, got.dst, got.val);
  endtask

  initial begin
    exp_t e;
    tick();
    tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check_reg("rst_r0", 0, 0);
    clr = 0;
    tick();

    wr(2, 5);
    wr(3, 7);
    check_reg("wr_r2", 2, 5);
    e = '{lat: 3, err: 0, mul: 0, dst: 1, val: 12, hv: 0, lv: 0};
    issue("add", OP_ADD, 1, 2, 3, e, 0);

    wr(4, 32'hFFFF_FFFD);
    wr(5, 6);
    e = '{lat: 4, err: 0, mul: 1, dst: 0, val: 0, hv: 32'hFFFF_FFFF, lv: 32'hFFFF_FFEE};
    issue("mul", OP_MUL, 0, 4, 5, e, 0);
    check_reg("mul_r4", 4, 32'hFFFF_FFFD);
    check_reg("mul_r5", 5, 6);
    check_reg("mul_r0", 0, 0);

    wr(6, 32'h0000_000F);
    wr(7, 4);
    e = '{lat: 3, err: 0, mul: 0, dst: 8, val: 32'hF000_0000, hv: 0, lv: 0};
    issue("ror", OP_ROR, 8, 6, 7, e, 0);
    wr(6, 32'h8000_0000);
    wr(7, 31);
    e = '{lat: 3, err: 0, mul: 0, dst: 8, val: 32'hFFFF_FFFF, hv: 0, lv: 0};
    issue("shra", OP_SHRA, 8, 6, 7, e, 0);
    wr(6, 32'h0000_000F);
    wr(7, 36);
    e = '{lat: 3, err: 0, mul: 0, dst: 8, val: 32'h0000_00F0, hv: 0, lv: 0};
    issue("shl36", OP_SHL, 8, 6, 7, e, 0);
    e = '{lat: 3, err: 0, mul: 0, dst: 9, val: 32'hFFFF_FFFE, hv: 0, lv: 0};
    issue("sub", OP_SUB, 9, 2, 3, e, 0);

    wr(1, 9);
    e = '{lat: 3, err: 0, mul: 0, dst: 1, val: 18, hv: 0, lv: 0};
    issue("alias", OP_ADD, 1, 1, 1, e, 0);
    check("b2b_in_done", done, 1);
    e = '{lat: 3, err: 0, mul: 0, dst: 1, val: 36, hv: 0, lv: 0};
    issue("b2b", OP_ADD, 1, 1, 1, e, 0);

    wr_addr = 2;
    wr_data = 32'hDEAD_BEEF;
    e = '{lat: 3, err: 0, mul: 0, dst: 10, val: 12, hv: 0, lv: 0};
    issue("poke", OP_ADD, 10, 2, 3, e, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("poke_no_done", done, 0);
    end
    check_reg("poke_r2", 2, 5);

    e = '{lat: 3, err: 1, mul: 0, dst: 2, val: 5, hv: 0, lv: 0};
    issue("illegal", 4'd13, 2, 2, 3, e, 0);
    check_reg("illegal_r3", 3, 7);
    check_reg("illegal_r1", 1, 36);

    op = OP_MUL; ra = 0; rb = 4; rc = 5; start = 1;
    tick();
    start = 0;
    tick();
    #2;
    clr = 1;
    #1;
    check("clr_busy", busy, 0);
    check("clr_done", done, 0);
    check("clr_err", err, 0);
    check("clr_hi", hi, 0);
    check("clr_lo", lo, 0);
    check_reg("clr_r4", 4, 0);
    check_reg("clr_r1", 1, 0);
    #3;
    clr = 0;
    for (int i = 0; i < 4; i++) tick();
    check("post_clr_hi", hi, 0);
    check("post_clr_lo", lo, 0);
    check("post_clr_done", done, 0);

    wr(2, 5);
    wr(3, 7);
    e = '{lat: 3, err: 0, mul: 0, dst: 1, val: 12, hv: 0, lv: 0};
    issue("add_after_clr", OP_ADD, 1, 2, 3, e, 0);

    check("queue_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
